// File: rtl/bitcast_unit.sv
// Bitcast execution engine: validates a bitcast descriptor and copies the source words unchanged to the destination.
// Optional macro BITCAST_OVERLAP_SAFE_EN: copy descending when the destination overlaps above the source.
module bitcast_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [112:0]      bitcast_in_tdata,
  input  logic              bitcast_in_tvalid,
  output logic              bitcast_in_tready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done_valid,
  output logic [1:0]        done_status
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_COPY  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [43:0] DEPTH = 44'd1 << ADDR_W;

  logic [2:0]        state;
  logic [4:0]        op;
  logic [29:0]       sdim_hi, ddim_hi;
  logic [ADDR_W-1:0] saddr, daddr;
  logic [2:0]        isz, osz;
  logic [39:0]       scnt, dcnt;
  logic [1:0]        calc_idx;
  logic [ADDR_W-1:0] remaining, rd_dst;
  logic              descending;

  logic [42:0]       sbytes, dbytes;
  logic [43:0]       words;
  logic [ADDR_W-1:0] last_off;
  logic              unsupported, mismatch, out_of_range, overlap_desc;

  // Only d1..d3 are kept; d0 seeds the running element count at capture.
  function automatic logic [9:0] dim_at(input logic [29:0] dims, input logic [1:0] k);
    case (k)
      2'd0:    dim_at = dims[9:0];
      2'd1:    dim_at = dims[19:10];
      default: dim_at = dims[29:20];
    endcase
  endfunction

  assign bitcast_in_tready = (state == ST_IDLE);
  assign mem_wr_data       = mem_wr_en ? mem_rd_data : '0;

  always_comb begin
    sbytes       = {3'b000, scnt} << isz[1:0];
    dbytes       = {3'b000, dcnt} << osz[1:0];
    words        = ({1'b0, sbytes} + 44'd3) >> 2;
    last_off     = ADDR_W'(words - 44'd1);
    unsupported  = (op != 5'd0) || isz[2] || osz[2];
    mismatch     = (sbytes != dbytes);
    out_of_range = ((44'(saddr) + words) > DEPTH) || ((44'(daddr) + words) > DEPTH);
`ifdef BITCAST_OVERLAP_SAFE_EN
    overlap_desc = (daddr > saddr) && (44'(daddr) < (44'(saddr) + words));
`else
    overlap_desc = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      op          <= '0;
      sdim_hi     <= '0;
      ddim_hi     <= '0;
      saddr       <= '0;
      daddr       <= '0;
      isz         <= '0;
      osz         <= '0;
      scnt        <= '0;
      dcnt        <= '0;
      calc_idx    <= '0;
      remaining   <= '0;
      rd_dst      <= '0;
      descending  <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      done_valid  <= 1'b0;
      done_status <= 2'd0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bitcast_in_tvalid) begin
            op       <= bitcast_in_tdata[112:108];
            sdim_hi  <= bitcast_in_tdata[107:78];
            scnt     <= {30'd0, bitcast_in_tdata[77:68]};
            ddim_hi  <= bitcast_in_tdata[67:38];
            dcnt     <= {30'd0, bitcast_in_tdata[37:28]};
            saddr    <= bitcast_in_tdata[27:17];
            daddr    <= bitcast_in_tdata[16:6];
            isz      <= bitcast_in_tdata[5:3];
            osz      <= bitcast_in_tdata[2:0];
            calc_idx <= 2'd0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          scnt     <= scnt * 40'(dim_at(sdim_hi, calc_idx));
          dcnt     <= dcnt * 40'(dim_at(ddim_hi, calc_idx));
          calc_idx <= calc_idx + 2'd1;
          if (calc_idx == 2'd2) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (unsupported || mismatch || out_of_range || (words == 44'd0)) begin
            done_status <= unsupported  ? 2'd1 :
                           mismatch     ? 2'd2 :
                           out_of_range ? 2'd3 : 2'd0;
            done_valid  <= 1'b1;
            state       <= ST_DONE;
          end else begin
            descending  <= overlap_desc;
            remaining   <= last_off;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= overlap_desc ? saddr + last_off : saddr;
            rd_dst      <= overlap_desc ? daddr + last_off : daddr;
            state       <= ST_COPY;
          end
        end
        ST_COPY: begin
          // Each read's write lands one cycle later, paired with the captured destination address.
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= rd_dst;
          if (remaining == '0) begin
            mem_rd_en <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            remaining <= remaining - ADDR_W'(1);
            if (descending) begin
              mem_rd_addr <= mem_rd_addr - ADDR_W'(1);
              rd_dst      <= rd_dst - ADDR_W'(1);
            end else begin
              mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
              rd_dst      <= rd_dst + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          mem_wr_en   <= 1'b0;
          done_status <= 2'd0;
          done_valid  <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcast_unit.sv
// Directed testbench for bitcast_unit with a behavioural scratchpad and hand-computed expectations.
// Descriptor handshake: tdata is taken on a rising edge where tvalid && tready are both high.
module tb_bitcast_unit;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [112:0] bitcast_in_tdata = '0;
  logic         bitcast_in_tvalid = 1'b0;
  logic         bitcast_in_tready;
  logic         mem_rd_en;
  logic [10:0]  mem_rd_addr;
  logic [31:0]  mem_rd_data;
  logic         mem_wr_en;
  logic [10:0]  mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic         done_valid;
  logic [1:0]   done_status;

  logic [31:0]  mem [0:2047];
  logic         tb_we = 1'b0;
  logic [10:0]  tb_wa = '0;
  logic [31:0]  tb_wd = '0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_wr = 0;
  int rd_start = 0;
  int wr_start = 0;
  logic rd_prev = 1'b0;
  logic wr_prev = 1'b0;
  int hs_q[$];

  bitcast_unit #(.DATA_W(32), .ADDR_W(11)) dut (
    .clock(clock), .reset(reset),
    .bitcast_in_tdata(bitcast_in_tdata), .bitcast_in_tvalid(bitcast_in_tvalid),
    .bitcast_in_tready(bitcast_in_tready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done_valid(done_valid), .done_status(done_status)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scratchpad: 1-cycle read latency, read samples the pre-write contents.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  always @(posedge clock)
    if (bitcast_in_tvalid && bitcast_in_tready) hs_q.push_back(cyc);

  always @(negedge clock) begin
    if (mem_rd_en) begin
      if (!rd_prev) rd_start = cyc;
      n_rd++;
    end
    if (mem_wr_en) begin
      if (!wr_prev) wr_start = cyc;
      n_wr++;
    end
    rd_prev = mem_rd_en;
    wr_prev = mem_wr_en;
  end

  int rd_base, wr_base;

  function automatic logic [39:0] dm(input logic [9:0] a, input logic [9:0] b,
                                     input logic [9:0] c, input logic [9:0] e);
    return {e, c, b, a};
  endfunction

  function automatic logic [112:0] mk(input logic [4:0] op, input logic [39:0] sd, input logic [39:0] dd,
                                      input logic [10:0] sa, input logic [10:0] da,
                                      input logic [2:0] is, input logic [2:0] os);
    return {op, sd, dd, sa, da, is, os};
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic poke(input logic [10:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic send(input logic [112:0] d, output int t0);
    @(negedge clock);
    rd_base = n_rd; wr_base = n_wr;
    bitcast_in_tdata = d; bitcast_in_tvalid = 1'b1;
    for (int k = 0; k < 100 && !bitcast_in_tready; k++) @(negedge clock);
    t0 = cyc;
    @(negedge clock);
    bitcast_in_tvalid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int t0, input int exp_lat,
                           input logic [1:0] exp_st, input int exp_n);
    int lat;
    logic [1:0] st;
    lat = -1; st = 2'bxx;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (done_valid) begin
        lat = cyc - t0; st = done_status; break;
      end
    end
    chk({tag, "_done_cycle"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_status"}, 64'(st), 64'(exp_st));
    chk({tag, "_reads"}, 64'(n_rd - rd_base), 64'(exp_n));
    chk({tag, "_writes"}, 64'(n_wr - wr_base), 64'(exp_n));
    if (exp_n > 0) begin
      chk({tag, "_first_read"}, 64'(rd_start - t0), 64'd5);
      chk({tag, "_first_write"}, 64'(wr_start - t0), 64'd6);
    end
  endtask

  int t0;
  int hb;
  logic [31:0] ovl_exp [4];

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_tready", 64'(bitcast_in_tready), 64'd1);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_status", 64'(done_status), 64'd0);
    chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(mem_wr_data), 64'd0);

    // Basic copy: 8 words 0x010 -> 0x100
    for (int i = 0; i < 8; i++) poke(11'h010 + 11'(i), 32'hA0 + 32'(i));
    send(mk(5'd0, dm(4, 2, 1, 1), dm(8, 1, 1, 1), 11'h010, 11'h100, 3'd2, 3'd2), t0);
    finish_op("basic", t0, 14, 2'd0, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("basic_mem%0d", i), 64'(mem[11'h100 + 11'(i)]), 64'(32'hA0 + 32'(i)));

    // Repack: 6 x 1B vs 3 x 2B -> 2 words
    poke(11'h030, 32'h1111_1111);
    poke(11'h031, 32'h2222_2222);
    send(mk(5'd0, dm(6, 1, 1, 1), dm(3, 1, 1, 1), 11'h030, 11'h140, 3'd0, 3'd1), t0);
    finish_op("repack", t0, 8, 2'd0, 2);
    chk("repack_mem0", 64'(mem[11'h140]), 64'h1111_1111);
    chk("repack_mem1", 64'(mem[11'h141]), 64'h2222_2222);

    // Errors
    send(mk(5'd1, dm(4, 2, 1, 1), dm(8, 1, 1, 1), 11'h010, 11'h100, 3'd2, 3'd2), t0);
    finish_op("unsupported_op", t0, 5, 2'd1, 0);
    send(mk(5'd0, dm(4, 1, 1, 1), dm(4, 1, 1, 1), 11'h010, 11'h100, 3'd4, 3'd2), t0);
    finish_op("unsupported_size", t0, 5, 2'd1, 0);
    send(mk(5'd0, dm(4, 1, 1, 1), dm(4, 1, 1, 1), 11'h010, 11'h100, 3'd2, 3'd1), t0);
    finish_op("size_mismatch", t0, 5, 2'd2, 0);
    send(mk(5'd0, dm(4, 1, 1, 1), dm(4, 1, 1, 1), 11'h7FE, 11'h200, 3'd2, 3'd2), t0);
    finish_op("range", t0, 5, 2'd3, 0);
    repeat (3) @(negedge clock);
    chk("range_status_held", 64'(done_status), 64'd3);
    chk("range_valid_pulse", 64'(done_valid), 64'd0);

    // Range boundary: last word exactly at the top of memory
    for (int i = 0; i < 4; i++) poke(11'h7FC + 11'(i), 32'hC0 + 32'(i));
    send(mk(5'd0, dm(4, 1, 1, 1), dm(2, 2, 1, 1), 11'h7FC, 11'h210, 3'd2, 3'd2), t0);
    finish_op("range_edge", t0, 10, 2'd0, 4);
    chk("range_edge_mem3", 64'(mem[11'h213]), 64'hC3);

    // Zero length
    send(mk(5'd0, dm(0, 5, 1, 1), dm(0, 1, 1, 1), 11'h010, 11'h300, 3'd2, 3'd2), t0);
    finish_op("zero_len", t0, 5, 2'd0, 0);

    // Back-to-back with tvalid held: second taken the cycle after the first done
    hb = hs_q.size();
    @(negedge clock);
    rd_base = n_rd; wr_base = n_wr;
    bitcast_in_tdata = mk(5'd1, dm(1, 1, 1, 1), dm(1, 1, 1, 1), 11'h000, 11'h000, 3'd2, 3'd2);
    bitcast_in_tvalid = 1'b1;
    t0 = cyc;
    @(negedge clock);
    bitcast_in_tdata = mk(5'd0, dm(2, 1, 1, 1), dm(1, 1, 1, 1), 11'h000, 11'h000, 3'd2, 3'd2);
    finish_op("b2b_first", t0, 5, 2'd1, 0);
    @(negedge clock);
    @(negedge clock);
    bitcast_in_tvalid = 1'b0;
    finish_op("b2b_second", t0, 11, 2'd2, 0);
    chk("b2b_handshakes", 64'(hs_q.size() - hb), 64'd2);
    if (hs_q.size() >= hb + 2) chk("b2b_gap", 64'(hs_q[hb + 1] - hs_q[hb]), 64'd6);

    // Reset during COPY
    send(mk(5'd0, dm(4, 2, 1, 1), dm(8, 1, 1, 1), 11'h010, 11'h180, 3'd2, 3'd2), t0);
    for (int k = 0; k < 50 && cyc < t0 + 7; k++) @(negedge clock);
    chk("mid_copy_active", 64'(mem_rd_en), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("mid_rst_done_valid", 64'(done_valid), 64'd0);
    chk("mid_rst_status", 64'(done_status), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_tready", 64'(bitcast_in_tready), 64'd1);

    // Overlap: src 0x20, dst 0x22, 4 words
    for (int i = 0; i < 4; i++) poke(11'h020 + 11'(i), 32'hA0 + 32'(i));
`ifdef BITCAST_OVERLAP_SAFE_EN
    ovl_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
`else
    ovl_exp = '{32'hA0, 32'hA1, 32'hA0, 32'hA1};
`endif
    send(mk(5'd0, dm(4, 1, 1, 1), dm(4, 1, 1, 1), 11'h020, 11'h022, 3'd2, 3'd2), t0);
    finish_op("overlap", t0, 10, 2'd0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("overlap_mem%0d", i), 64'(mem[11'h022 + 11'(i)]), 64'(ovl_exp[i]));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
